// File: rtl/arb_pkg.sv
// Shared constants for the memory port arbiter.
//   OWNER_INST / OWNER_DATA : owner tag stored per outstanding transaction
//   OST_DEPTH_DEFAULT       : default outstanding-transaction capacity
package arb_pkg;
  localparam logic OWNER_INST        = 1'b0;
  localparam logic OWNER_DATA        = 1'b1;
  localparam int   OST_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// owner_fifo: 1-bit wide, DEPTH-deep FIFO of transaction owner tags.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   push_i, din_i      : enqueue a tag (caller guarantees !full_o)
//   pop_i              : dequeue head (ignored when empty)
//   full_o, empty_o    : occupancy flags
//   head_o             : tag at the head (don't-care when empty)
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges an instruction and a data sram-like master onto
// one downstream sram-like port, zero added latency on both paths.
// Ports:
//   clk, resetn                     : clock, synchronous active-low reset
//   inst_sram_* / data_sram_*       : master request channels and responses
//   mem_*                           : shared downstream port
//   arb_err                         : sticky, set by data_ok with nothing outstanding
// Config macro ARB_ROUND_ROBIN_EN: round-robin grant when both masters request;
// otherwise the data master has fixed priority.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int OST_DEPTH = OST_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);
  logic grant_data, hs, full, empty, head, pop;
  logic arb_err_q, arb_err_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On contention the master that did not win last time gets the port.
  always_comb begin
    grant_data = data_sram_req;
    if (inst_sram_req && data_sram_req) grant_data = (last_grant_q == OWNER_INST);
  end

  assign last_grant_d = hs ? grant_data : last_grant_q;

  always_ff @(posedge clk) begin
    if (!resetn) last_grant_q <= OWNER_INST;
    else         last_grant_q <= last_grant_d;
  end
`else
  assign grant_data = data_sram_req;
`endif

  // Full blocks requests on count alone so no data_ok -> req path exists.
  assign mem_req   = (inst_sram_req | data_sram_req) & ~full;
  assign mem_wr    = grant_data ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = grant_data ? data_sram_size  : inst_sram_size;
  assign mem_addr  = grant_data ? data_sram_addr  : inst_sram_addr;
  assign mem_wstrb = grant_data ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_wdata = grant_data ? data_sram_wdata : inst_sram_wdata;

  assign hs                = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = hs & ~grant_data;
  assign data_sram_addr_ok = hs &  grant_data;

  assign pop               = mem_data_ok & ~empty;
  assign inst_sram_data_ok = pop & (head == OWNER_INST);
  assign data_sram_data_ok = pop & (head == OWNER_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : 32'h0;
  assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : 32'h0;

  assign arb_err_d = arb_err_q | (mem_data_ok & empty);
  assign arb_err   = arb_err_q;

  always_ff @(posedge clk) begin
    if (!resetn) arb_err_q <= 1'b0;
    else         arb_err_q <= arb_err_d;
  end

  owner_fifo #(.DEPTH(OST_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (hs),
    .din_i   (grant_data ? OWNER_DATA : OWNER_INST),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );
endmodule
